uart_tx_scheduler: RTL and testbench

Shares one UART transmitter between several byte producers, such as the CPU MMIO write path and a hardware echo/loopback path. Requesters hand off bytes over a valid/ready handshake. A round-robin arbiter admits at most one byte per cycle into a small FIFO. A sequencer FSM drains the FIFO into the UART sender with a one-cycle start pulse, then waits for the sender's completion pulse. The block sits between the MMIO/peripheral layer and the UART sender, on the system clock domain.

---
 rtl/uart_sched_pkg.sv | 20 ++
 rtl/uart_sched_fifo.sv | 62 ++++++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds sequencer state codes, default sizing constants and the level width helper.
package uart_sched_pkg;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 1_000_000;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_WAIT  = 2'd2;

    // Occupancy needs one extra bit so that "full" (level == depth) is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sched_fifo.sv
// Byte FIFO for the UART transmit scheduler: DEPTH x 8 circular buffer.
// Ports: clk, reset, push/push_data, pop, head (current front byte), level, full, empty.
module uart_sched_fifo
    import uart_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [7:0]                push_data,
    input  logic                      pop,
    output logic [7:0]                head,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART sender between NREQ byte producers: round-robin arbiter, FIFO, sequencer.
// Ports: req_valid/req_data/req_ready (producers), tx_start/tx_data/tx_done (sender), busy, level, sent_pulse, timeout_err.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      sent_pulse,
    output logic                      timeout_err
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant_idx;
    logic [GW-1:0] cand;
    logic          grant_any;
    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    state_t        state;
    logic [CW-1:0] cnt;

    // Round-robin search starting just after the last requester served.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = GW'((int'(last_grant) + 1 + i) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ready looks only at the registered level, never at a same-cycle pop.
    always_comb begin
        req_ready = '0;
        if (!reset && !full && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign push      = |req_ready;
    assign push_data = req_data[{grant_idx, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GW'(NREQ - 1);
        end else if (push) begin
            last_grant <= grant_idx;
        end
    end

    uart_sched_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    assign pop      = (state == S_IDLE) && !empty;
    assign tx_start = (state == S_START);
    assign busy     = (state != S_IDLE) || !empty;

    // tx_done is only honoured in S_WAIT; late completions from a frame
    // abandoned by reset or timeout fall into IDLE/START and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tx_data     <= 8'h00;
            cnt         <= '0;
            sent_pulse  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sent_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        tx_data <= head;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        sent_pulse <= 1'b1;
                        state      <= S_IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-based reference model plus directed scenarios.
// Model is checked every negedge; directed scenarios add literal expectations and random traffic follows.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 2;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [3:0]  level;
    logic        sent_pulse;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ   (NREQ),
        .DEPTH  (DEPTH),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .level      (level),
        .sent_pulse (sent_pulse),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, owner of the sender, age since pop.
    byte unsigned mq[$];
    byte unsigned txlog[$];
    int           m_lg = NREQ - 1;
    bit           m_act;
    int           m_age;
    logic [7:0]   m_data;
    bit           m_sent;
    bit           m_err;
    logic [1:0]   lr;
    logic [1:0]   er;
    int           g;
    bit           pop_now;
    bit           sent_n;

    always @(negedge clk) begin
        lr = req_ready;
        if (tx_start) txlog.push_back(tx_data);
        if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_level", level, 0);
            chk("rst_sent", sent_pulse, 0);
            chk("rst_err", timeout_err, 0);
            mq.delete();
            m_lg   = NREQ - 1;
            m_act  = 0;
            m_age  = 0;
            m_data = 8'h00;
            m_sent = 0;
            m_err  = 0;
        end else begin
            g = -1;
            if (mq.size() < DEPTH) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (g < 0 && ((int'(req_valid) >> ((m_lg + 1 + i) % NREQ)) & 1) == 1)
                        g = (m_lg + 1 + i) % NREQ;
                end
            end
            er = (g >= 0) ? 2'(1 << g) : 2'b00;
            chk("req_ready", req_ready, er);
            chk("tx_start", tx_start, m_act && m_age == 0);
            chk("tx_data", tx_data, m_data);
            chk("busy", busy, m_act || mq.size() != 0);
            chk("level", level, mq.size());
            chk("sent_pulse", sent_pulse, m_sent);
            chk("timeout_err", timeout_err, m_err);
            sent_n  = 0;
            pop_now = !m_act && mq.size() != 0;
            if (m_act) begin
                if (m_age >= 1 && tx_done) begin
                    m_act  = 0;
                    sent_n = 1;
                end else if (m_age >= TO) begin
                    m_act = 0;
                    m_err = 1;
                end else begin
                    m_age++;
                end
            end
            if (pop_now) begin
                m_data = mq.pop_front();
                m_act  = 1;
                m_age  = 0;
            end
            if (g >= 0) begin
                mq.push_back(8'(req_data >> (8 * g)));
                m_lg = g;
            end
            m_sent = sent_n;
        end
    end

    // Sender stub: completes each frame after a random delay, may stall or glitch.
    bit auto_en;
    int dmax = 3;
    int stall_pct;
    bit spur;
    int cd;

    always begin
        @(posedge clk);
        #1;
        if (auto_en) begin
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
            if (tx_start) begin
                if ($urandom_range(0, 99) < stall_pct) cd = 0;
                else cd = $urandom_range(1, dmax);
            end
            if (spur && $urandom_range(0, 29) == 0) tx_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step();
        auto_en   = 0;
        cd        = 0;
        tx_done   = 0;
        req_valid = '0;
        reset     = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic send0(input logic [7:0] d);
        bit ok;
        ok = 0;
        step();
        req_valid[0]  = 1'b1;
        req_data[7:0] = d;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            if (lr[0]) ok = 1;
        end
        req_valid[0] = 1'b0;
        chk("send_ack", ok, 1);
    endtask

    task automatic wait_start(input string nm, input int lim);
        bit got;
        got = 0;
        for (int c = 0; c < lim && !got; c++) begin
            @(negedge clk);
            if (tx_start) got = 1;
        end
        chk(nm, got, 1);
    endtask

    int  c0;
    int  c1;
    int  cnt;
    bit  seen8;
    bit  got9;
    bit  acc;

    initial begin
        reset     = 1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 0;
        auto_en   = 0;
        repeat (3) step();
        @(negedge clk);
        chk("init_level", level, 0);
        chk("init_busy", busy, 0);
        step();
        reset = 0;

        // Single byte from requester 0.
        send0(8'hA5);
        @(negedge clk);
        chk("t1_level", level, 1);
        chk("t1_nostart", tx_start, 0);
        step();
        @(negedge clk);
        chk("t1_start", tx_start, 1);
        chk("t1_data", tx_data, 8'hA5);
        repeat (5) step();
        tx_done = 1;
        step();
        tx_done = 0;
        @(negedge clk);
        chk("t1_sent", sent_pulse, 1);
        step();
        @(negedge clk);
        chk("t1_sent_once", sent_pulse, 0);
        chk("t1_idle", busy, 0);

        // Fairness: both requesters hold valid.
        reset_dut();
        auto_en   = 1;
        dmax      = 3;
        stall_pct = 0;
        spur      = 0;
        txlog.delete();
        c0        = 0;
        c1        = 0;
        req_data  = {8'h20, 8'h10};
        req_valid = 2'b11;
        for (int c = 0; c < 200 && (c0 < 4 || c1 < 4); c++) begin
            step();
            if (lr[0]) begin
                c0++;
                req_data[7:0] = 8'(8'h10 + c0);
                if (c0 == 4) req_valid[0] = 1'b0;
            end
            if (lr[1]) begin
                c1++;
                req_data[15:8] = 8'(8'h20 + c1);
                if (c1 == 4) req_valid[1] = 1'b0;
            end
        end
        for (int c = 0; c < 300 && txlog.size() < 8; c++) step();
        chk("fair_count", txlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < txlog.size())
                chk("fair_order", txlog[i], (i % 2 == 0) ? 8'h10 + i / 2 : 8'h20 + i / 2);
        end

        // Timeout with tx_done withheld.
        reset_dut();
        send0(8'h77);
        wait_start("to_start", 10);
        repeat (16) @(negedge clk);
        chk("to_not_yet", timeout_err, 0);
        @(negedge clk);
        chk("to_set", timeout_err, 1);
        send0(8'h78);
        wait_start("to_next_start", 10);
        chk("to_next_data", tx_data, 8'h78);
        chk("to_sticky", timeout_err, 1);

        // Full FIFO while the sequencer holds a stalled frame.
        reset_dut();
        send0(8'h30);
        cnt           = 0;
        seen8         = 0;
        got9          = 0;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h31;
        for (int c = 0; c < 100 && !got9; c++) begin
            @(negedge clk);
            acc = req_ready[0];
            if (level == 4'd8 && !seen8) begin
                seen8 = 1;
                chk("full_ready", req_ready, 0);
            end
            if (acc && cnt == 8) begin
                got9 = 1;
                chk("ninth_level", level, 7);
                chk("ninth_after_pop", tx_start, 1);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                cnt++;
                req_data[7:0] = 8'(8'h31 + cnt);
                if (cnt == 9) req_valid[0] = 1'b0;
            end
        end
        req_valid = '0;
        chk("full_seen", seen8, 1);
        chk("ninth_seen", got9, 1);

        // Push in the same cycle as the pop keeps the level.
        reset_dut();
        send0(8'h50);
        wait_start("pp_start", 10);
        for (int i = 1; i <= 3; i++) send0(8'(8'h50 + i));
        @(negedge clk);
        chk("pp_level3", level, 3);
        step();
        tx_done = 1;
        step();
        tx_done       = 0;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h54;
        @(negedge clk);
        chk("pp_ready", req_ready, 1);
        chk("pp_pre_level", level, 3);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("pp_level", level, 3);
        chk("pp_start2", tx_start, 1);
        chk("pp_data", tx_data, 8'h51);

        // Pointer wrap: 20 bytes in order.
        reset_dut();
        auto_en   = 1;
        dmax      = 2;
        stall_pct = 0;
        spur      = 0;
        txlog.delete();
        c1             = 0;
        req_data[15:8] = 8'h40;
        req_valid      = 2'b10;
        for (int c = 0; c < 500 && c1 < 20; c++) begin
            step();
            if (lr[1]) begin
                c1++;
                req_data[15:8] = 8'(8'h40 + c1);
                if (c1 == 20) req_valid[1] = 1'b0;
            end
        end
        for (int c = 0; c < 500 && txlog.size() < 20; c++) step();
        chk("wrap_count", txlog.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < txlog.size()) chk("wrap_order", txlog[i], 8'h40 + i);
        end

        // Reset in the middle of a frame with bytes queued.
        reset_dut();
        send0(8'h60);
        wait_start("mr_start", 10);
        for (int i = 1; i <= 4; i++) send0(8'(8'h60 + i));
        @(negedge clk);
        chk("mr_level4", level, 4);
        step();
        reset = 1;
        @(negedge clk);
        chk("mr_level", level, 0);
        chk("mr_busy", busy, 0);
        chk("mr_data", tx_data, 0);
        chk("mr_start_low", tx_start, 0);
        step();
        reset = 0;
        step();
        tx_done = 1;
        step();
        tx_done = 0;
        @(negedge clk);
        chk("mr_late_done", sent_pulse, 0);
        chk("mr_late_busy", busy, 0);

        // Random traffic against the model.
        reset_dut();
        auto_en   = 1;
        dmax      = 22;
        stall_pct = 5;
        spur      = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = 2'($urandom);
            req_data  = 16'($urandom);
        end
        step();
        reset     = 0;
        req_valid = '0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
